// File: rtl/risc_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_controller_pkg
//  Description : Shared opcode and sequencer-phase constants for the RISC
//                controller, ALU and instruction register.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_controller_pkg;

    // Instruction opcodes
    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // Sequencer phases
    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    // True for opcodes that read an operand and load the accumulator
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_controller_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : phase_counter
//  Description : 3-bit sequencer phase counter, synchronous active-high reset,
//                counts up and wraps 7 -> 0 while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_counter
    import risc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] count
);

    logic [2:0] r_count;

    // Reset to the first phase; otherwise step by one when enabled (natural wrap)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= INST_ADDR;
        end else if (en) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : risc_controller
//  Description : Eight-phase sequencer for a simple accumulator RISC. Control
//                strobes are decoded combinationally from the registered phase,
//                the sticky halt flag and the live opcode/zero inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_controller
    import risc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr
);

    logic [2:0] w_phase;
    logic       r_halt;
    logic       w_aluop;

    // The counter stops once halted; halt sets on the 4->5 edge, so it freezes at 5
    phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (!r_halt),
        .count (w_phase)
    );

    // Sticky halt flag: set when a HLT instruction reaches the operand-address phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else if (!r_halt && (w_phase == OP_ADDR) && (opcode == HLT)) begin
            r_halt <= 1'b1;
        end
    end

    assign w_aluop = is_aluop(opcode);

    // Strobe decode; everything defaults low so a halted core drives nothing
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (!r_halt) begin
            case (w_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    rd = w_aluop;
                end
                ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                    wr     = (opcode == STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = w_phase;
    assign halt  = r_halt;

endmodule
`default_nettype wire
